// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: sequential fetch with one outstanding memory request,
// a small PC/instruction FIFO toward decode, and redirect-driven flush/restart.
module if_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [31:0]        fetch_pc;
  logic [31:0]        req_pc;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [31:0]        fifo_pc    [DEPTH];
  logic [31:0]        fifo_instr [DEPTH];

  logic req_accept;
  logic resp_take;
  logic pop;

  // Target word alignment drops the two low bits of the branch target.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign req_accept    = imem_req_valid && imem_req_ready;
  assign resp_take     = (state == S_WAIT) && imem_resp_valid && !redirect_valid && !reset;
  assign pop           = id_valid && id_ready;
  assign imem_req_addr = fetch_pc;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    state <= state_next;
  end

  // Reset is folded in here because the post-reset state depends on whether a
  // request was in flight when reset hit.
  always_comb begin
    state_next = state;
    if (reset) begin
      if (state == S_WAIT || state == S_DROP) state_next = S_DROP;
      else                                    state_next = S_REQ;
    end else begin
      case (state)
        S_REQ:   if (req_accept) state_next = S_WAIT;
        S_WAIT: begin
          if (imem_resp_valid)     state_next = S_REQ;
          else if (redirect_valid) state_next = S_DROP;
        end
        S_DROP:  if (imem_resp_valid) state_next = S_REQ;
        default: state_next = S_REQ;
      endcase
    end
  end

  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    imem_req_valid = 1'b0;
    id_valid       = 1'b0;
    id_instruction = '0;
    id_pc          = '0;
    if (state == S_REQ && count < CNT_W'(DEPTH) && !redirect_valid && !reset)
      imem_req_valid = 1'b1;
    if (count != '0) begin
      id_valid       = !redirect_valid && !reset;
      id_instruction = fifo_instr[rd_ptr];
      id_pc          = fifo_pc[rd_ptr];
    end
  end

  // Redirect outranks everything: flush, no pop, restart at the aligned target.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (req_accept) begin
        fetch_pc <= fetch_pc + 32'd4;
        req_pc   <= fetch_pc;
      end
      if (resp_take) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)       rd_ptr <= rd_ptr + PTR_W'(1);
      case ({resp_take, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: FIFO storage is not reset; count and pointers alone decide validity,
  // and leaving the array unreset lets it map onto plain register/RAM cells.
  always_ff @(posedge clk) begin
    if (resp_take) begin
      fifo_pc[wr_ptr]    <= req_pc;
      fifo_instr[wr_ptr] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: directed scenarios with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_if_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;

  int n_tests = 0;
  int n_fail  = 0;
  int lat     = 1;
  bit model_on = 1'b0;

  if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instruction (id_instruction),
    .id_pc          (id_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: one response per accepted request, lat cycles after acceptance.
  bit          mem_acc;
  logic [31:0] mem_acc_addr;
  bit          mem_pend = 1'b0;
  int          mem_wait = 0;
  logic [31:0] mem_addr = '0;
  always begin
    @(negedge clk);
    mem_acc      = imem_req_valid && imem_req_ready;
    mem_acc_addr = imem_req_addr;
    @(posedge clk);
    #1;
    if (mem_acc) begin
      mem_pend = 1'b1;
      mem_wait = lat - 1;
      mem_addr = mem_acc_addr;
    end
    imem_resp_valid = 1'b0;
    if (mem_pend) begin
      if (mem_wait == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mem_addr);
        mem_pend        = 1'b0;
      end else begin
        mem_wait--;
      end
    end
  end

  // Reference model: buffered entries in a queue, plus what kind of request
  // (none / live / stale) the memory still owes us.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;
  typedef enum {OUT_NONE, OUT_LIVE, OUT_STALE} out_e;

  entry_t      mq[$];
  out_e        m_out    = OUT_NONE;
  logic [31:0] m_pc     = RESET_PC;
  logic [31:0] m_req_pc = '0;
  logic        exp_rv, exp_iv;
  logic [31:0] exp_ipc, exp_ins;

  always @(negedge clk) begin
    if (model_on) begin
      exp_rv  = !reset && !redirect_valid && m_out == OUT_NONE && mq.size() < DEPTH;
      exp_iv  = !reset && !redirect_valid && mq.size() != 0;
      exp_ipc = (mq.size() != 0) ? mq[0].pc : 32'h0;
      exp_ins = (mq.size() != 0) ? mq[0].instr : 32'h0;
      check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      check("req_addr", imem_req_addr, m_pc);
      check("id_valid", 32'(id_valid), 32'(exp_iv));
      check("id_pc", id_pc, exp_ipc);
      check("id_instruction", id_instruction, exp_ins);

      if (reset) begin
        mq.delete();
        m_pc = RESET_PC;
        if (m_out != OUT_NONE) m_out = OUT_STALE;
      end else if (redirect_valid) begin
        mq.delete();
        m_pc = redirect_pc & 32'hFFFF_FFFC;
        if (m_out != OUT_NONE) m_out = imem_resp_valid ? OUT_NONE : OUT_STALE;
      end else begin
        if (exp_iv && id_ready) void'(mq.pop_front());
        if (m_out != OUT_NONE && imem_resp_valid) begin
          if (m_out == OUT_LIVE) mq.push_back('{pc: m_req_pc, instr: imem_resp_data});
          m_out = OUT_NONE;
        end else if (exp_rv && imem_req_ready) begin
          m_req_pc = m_pc;
          m_pc     = m_pc + 32'd4;
          m_out    = OUT_LIVE;
        end
      end
    end
  end

  // Inputs change 2 time units after each rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic fresh();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    tick(8);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  // Accept requests until the one to address a is presented, then stall it.
  task automatic hold_at(input logic [31:0] a);
    logic found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (imem_req_valid && imem_req_addr == a) begin
        imem_req_ready = 1'b0;
        found = 1'b1;
      end else begin
        imem_req_ready = 1'b1;
        tick(1);
      end
    end
    check("hold_at_reached", 32'(found), 32'd1);
  endtask

  task automatic wait_resp();
    logic found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (imem_resp_valid) found = 1'b1;
      else tick(1);
    end
    check("resp_seen", 32'(found), 32'd1);
  endtask

  task automatic wait_id();
    logic found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (id_valid) found = 1'b1;
      else tick(1);
    end
    check("id_valid_seen", 32'(found), 32'd1);
  endtask

  initial begin
    tick(1);
    model_on = 1'b1;

    // Sequential fetch with a 1-cycle memory.
    fresh();
    lat = 1; id_ready = 1'b1; imem_req_ready = 1'b1;
    #1 check("t1_first_valid", 32'(imem_req_valid), 32'd1);
    check("t1_first_addr", imem_req_addr, 32'h0);
    tick(2);
    #1 check("t1_id_pc0", id_pc, 32'h0);
    check("t1_id_ins0", id_instruction, mem_word(32'h0));
    check("t1_addr4", imem_req_addr, 32'h4);
    tick(2);
    #1 check("t1_id_pc4", id_pc, 32'h4);
    check("t1_addr8", imem_req_addr, 32'h8);

    // FIFO fills with decode stalled, then one pop frees a slot.
    fresh();
    lat = 1; id_ready = 1'b0; imem_req_ready = 1'b1;
    tick(12);
    #1 check("t2_full_no_req", 32'(imem_req_valid), 32'd0);
    check("t2_full_head", id_pc, 32'h0);
    id_ready = 1'b1;
    tick(1);
    id_ready = 1'b0;
    #1 check("t2_req_after_pop", 32'(imem_req_valid), 32'd1);
    check("t2_addr_10", imem_req_addr, 32'h10);
    check("t2_head_after_pop", id_pc, 32'h4);

    // Request held stable under backpressure.
    fresh();
    lat = 1; id_ready = 1'b1;
    hold_at(32'h8);
    for (int i = 0; i < 3; i++) begin
      #1 check("t3_hold_valid", 32'(imem_req_valid), 32'd1);
      check("t3_hold_addr", imem_req_addr, 32'h8);
      tick(1);
    end
    imem_req_ready = 1'b1;
    #1 check("t3_accept_addr", imem_req_addr, 32'h8);
    tick(1);
    #1 check("t3_accepted", 32'(imem_req_valid), 32'd0);

    // Redirect while a slow response is in flight.
    fresh();
    lat = 3; id_ready = 1'b1;
    hold_at(32'h8);
    imem_req_ready = 1'b1;
    #1 check("t4_accept_addr", imem_req_addr, 32'h8);
    tick(1);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1 check("t4_redir_id_valid", 32'(id_valid), 32'd0);
    tick(1);
    redirect_valid = 1'b0;
    #1 check("t4_flushed", 32'(id_valid), 32'd0);
    check("t4_stale_no_req", 32'(imem_req_valid), 32'd0);
    tick(1);
    #1 check("t4_drop_no_req", 32'(imem_req_valid), 32'd0);
    check("t4_drop_no_push", 32'(id_valid), 32'd0);
    tick(1);
    #1 check("t4_target_valid", 32'(imem_req_valid), 32'd1);
    check("t4_target_addr", imem_req_addr, 32'h40);
    wait_id();
    check("t4_target_id_pc", id_pc, 32'h40);

    // Redirect coincident with a response; target is realigned.
    fresh();
    lat = 2; id_ready = 1'b1; imem_req_ready = 1'b1;
    wait_resp();
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    #1 check("t5_id_valid_low", 32'(id_valid), 32'd0);
    tick(1);
    redirect_valid = 1'b0;
    #1 check("t5_req_valid", 32'(imem_req_valid), 32'd1);
    check("t5_req_addr", imem_req_addr, 32'h100);
    check("t5_not_pushed", 32'(id_valid), 32'd0);

    // Address wrap at the top of the space.
    fresh();
    lat = 1; id_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick(1);
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    #1 check("t6_top_addr", imem_req_addr, 32'hFFFF_FFFC);
    tick(2);
    #1 check("t6_wrap_addr", imem_req_addr, 32'h0);
    check("t6_wrap_valid", 32'(imem_req_valid), 32'd1);
    check("t6_top_id_pc", id_pc, 32'hFFFF_FFFC);

    // Reset while a request is outstanding; its late response is dropped.
    fresh();
    lat = 3; id_ready = 1'b1; imem_req_ready = 1'b1;
    #1 check("t7_accept_addr", imem_req_addr, 32'h0);
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    #1 check("t7_stale_no_req", 32'(imem_req_valid), 32'd0);
    tick(1);
    #1 check("t7_drop_no_req", 32'(imem_req_valid), 32'd0);
    tick(1);
    #1 check("t7_restart_addr", imem_req_addr, 32'h0);
    check("t7_restart_valid", 32'(imem_req_valid), 32'd1);
    check("t7_no_stale_push", 32'(id_valid), 32'd0);

    // Randomized traffic, compared cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      id_ready       = ($urandom_range(0, 3) < ((c / 400) % 4) + 1);
      lat            = $urandom_range(1, 5);
      redirect_valid = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else                           redirect_pc = $urandom;
      tick(1);
    end
    redirect_valid = 1'b0;
    tick(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
